grid_mover: RTL

//  Synchronous player-movement controller for the tile map. Turns debounced active-low buttons

---
 rtl/grid_mover.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/grid_mover.sv
// Player-movement controller for the tile map: button events with auto-repeat,
// map-RAM walkability check over a req/ack read port, then commit or bump.
module grid_mover #(
    parameter int unsigned        GRID_W        = 11,
    parameter int unsigned        GRID_H        = 11,
    parameter int unsigned        COORD_W       = 4,
    parameter int unsigned        ADDR_W        = 19,
    parameter int unsigned        TILE_W        = 16,
    parameter logic [TILE_W-1:0]  SOLID_MASK    = TILE_W'(32'h8000),
    parameter bit                 WRAP          = 1'b0,
    parameter int unsigned        START_X       = 0,
    parameter int unsigned        START_Y       = 0,
    parameter int unsigned        REPEAT_DELAY  = 50_000_000,
    parameter int unsigned        REPEAT_PERIOD = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         btn_n,
    output logic               map_rd_req,
    output logic [ADDR_W-1:0]  map_rd_addr,
    input  logic               map_rd_ack,
    input  logic [TILE_W-1:0]  map_rd_data,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               moved,
    output logic               bumped,
    output logic               busy
);

    localparam int unsigned EXT_W   = COORD_W + 1;
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_COMMIT, S_BUMP} state_t;

    state_t             state;
    logic [3:0]         btn_q;
    logic               prev_vld;
    logic [1:0]         prev_dir;
    logic [CNT_W-1:0]   cnt;
    logic               first_rep;
    logic               pend_vld;
    logic [1:0]         pend_dir;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;

    logic               dir_vld_c;
    logic [1:0]         dir_c;
    logic               new_dir_c;
    logic               rep_hit_c;
    logic               event_c;
    logic               start_c;
    logic [1:0]         go_dir_c;
    logic [EXT_W-1:0]   tx_ext_c;
    logic [EXT_W-1:0]   ty_ext_c;
    logic               off_x_c;
    logic               off_y_c;
    logic               edge_c;
    logic [COORD_W-1:0] tgt_x_c;
    logic [COORD_W-1:0] tgt_y_c;
    logic [ADDR_W-1:0]  addr_c;

    // Active direction is the lowest-index pressed button.
    always_comb begin
        dir_vld_c = 1'b0;
        dir_c     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!btn_q[i]) begin
                dir_vld_c = 1'b1;
                dir_c     = 2'(i);
            end
        end
        new_dir_c = dir_vld_c && (!prev_vld || (prev_dir != dir_c));
        rep_hit_c = dir_vld_c && !new_dir_c &&
                    (cnt == (first_rep ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD)));
        event_c   = new_dir_c || rep_hit_c;
        start_c   = (state == S_IDLE) && (event_c || pend_vld);
        go_dir_c  = event_c ? dir_c : pend_dir;
    end

    // Target computed one bit wider so that 0-1 shows up as off-map.
    always_comb begin
        tx_ext_c = {1'b0, pos_x};
        ty_ext_c = {1'b0, pos_y};
        case (go_dir_c)
            2'd0: ty_ext_c = ty_ext_c - EXT_W'(1);
            2'd1: ty_ext_c = ty_ext_c + EXT_W'(1);
            2'd2: tx_ext_c = tx_ext_c - EXT_W'(1);
            2'd3: tx_ext_c = tx_ext_c + EXT_W'(1);
        endcase
        off_x_c = tx_ext_c >= EXT_W'(GRID_W);
        off_y_c = ty_ext_c >= EXT_W'(GRID_H);
        tgt_x_c = tx_ext_c[COORD_W-1:0];
        tgt_y_c = ty_ext_c[COORD_W-1:0];
        if (WRAP) begin
            if (off_x_c) tgt_x_c = (go_dir_c == 2'd2) ? COORD_W'(GRID_W - 1) : '0;
            if (off_y_c) tgt_y_c = (go_dir_c == 2'd0) ? COORD_W'(GRID_H - 1) : '0;
        end
        edge_c = !WRAP && (off_x_c || off_y_c);
        addr_c = ADDR_W'(tgt_y_c) * ADDR_W'(GRID_W) + ADDR_W'(tgt_x_c);
    end

    // Button register and hold auto-repeat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q     <= 4'hF;
            prev_vld  <= 1'b0;
            prev_dir  <= 2'd0;
            cnt       <= '0;
            first_rep <= 1'b1;
        end else begin
            btn_q    <= btn_n;
            prev_vld <= dir_vld_c;
            prev_dir <= dir_c;
            if (!dir_vld_c) begin
                cnt       <= '0;
                first_rep <= 1'b1;
            end else if (new_dir_c) begin
                cnt       <= CNT_W'(1);
                first_rep <= 1'b1;
            end else if (rep_hit_c) begin
                cnt       <= CNT_W'(1);
                first_rep <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Move FSM with registered outputs and one-deep pending slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pos_x       <= COORD_W'(START_X);
            pos_y       <= COORD_W'(START_Y);
            tgt_x       <= '0;
            tgt_y       <= '0;
            map_rd_req  <= 1'b0;
            map_rd_addr <= '0;
            moved       <= 1'b0;
            bumped      <= 1'b0;
            busy        <= 1'b0;
            pend_vld    <= 1'b0;
            pend_dir    <= 2'd0;
        end else begin
            moved  <= 1'b0;
            bumped <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        pend_vld <= 1'b0;
                        tgt_x    <= tgt_x_c;
                        tgt_y    <= tgt_y_c;
                        busy     <= 1'b1;
                        if (edge_c) begin
                            state  <= S_BUMP;
                            bumped <= 1'b1;
                        end else begin
                            state       <= S_READ;
                            map_rd_req  <= 1'b1;
                            map_rd_addr <= addr_c;
                        end
                    end
                end
                S_READ: begin
                    if (map_rd_ack) begin
                        map_rd_req <= 1'b0;
                        if ((map_rd_data & SOLID_MASK) != '0) begin
                            state  <= S_BUMP;
                            bumped <= 1'b1;
                        end else begin
                            state <= S_COMMIT;
                            moved <= 1'b1;
                            pos_x <= tgt_x;
                            pos_y <= tgt_y;
                        end
                    end
                end
                S_COMMIT, S_BUMP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if ((state != S_IDLE) && event_c) begin
                pend_vld <= 1'b1;
                pend_dir <= dir_c;
            end
        end
    end

endmodule
